// File: rtl/clk_div_monitor.sv
// clk_div_monitor
// Measures the high and low phase lengths of a slow clock (clk_in) in cycles
// of the fast system clock. It reports the period and the 50% duty flag, and
// asserts lock once the same (high,low) pair has been seen LOCK_CNT times in a
// row. A sticky timeout flag is raised when clk_in stops toggling.
module clk_div_monitor #(
    parameter int  MAX_DIV     = 256,
    parameter int  LOCK_CNT    = 4,
    parameter int  SYNC_STAGES = 2,
    localparam int W           = $clog2(MAX_DIV + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clk_in,
    output logic [W-1:0] high_len,
    output logic [W-1:0] low_len,
    output logic [W:0]   period,
    output logic         valid,
    output logic         is_even,
    output logic         locked,
    output logic         timeout_err
);

    localparam int MW = $clog2(LOCK_CNT + 1);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_RISE = 2'd1;
    localparam logic [1:0] ST_MEASURE   = 2'd2;
    localparam logic [1:0] ST_LOCKED    = 2'd3;

    localparam logic [W-1:0]  CNT_MAX   = W'(MAX_DIV);
    localparam logic [MW-1:0] MATCH_MAX = MW'(LOCK_CNT);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   s_d;
    logic                   rise;
    logic                   fall;
    logic                   any_edge;
    logic [W-1:0]           cnt;
    logic [W-1:0]           hi_tmp;
    logic                   have_fall;
    logic [1:0]             state;
    logic [MW-1:0]          match_cnt;
    logic [MW-1:0]          match_nxt;
    logic                   pair_same;
    logic                   take_sample;
    logic                   timeout_hit;

    // Bring clk_in into the clk domain and keep a one-cycle delayed copy.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, which is what makes the
    // shift chain a chain instead of a single flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], clk_in};
            s_d    <= s;
        end
    end

    assign s        = sync_q[SYNC_STAGES-1];
    assign rise     = s & ~s_d;
    assign fall     = ~s & s_d;
    assign any_edge = rise | fall;

    // Phase counter: restarts at 1 on every edge, so on an edge cycle it
    // holds the length of the phase that just ended; saturates at MAX_DIV.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (any_edge) begin
            cnt <= W'(1);
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + W'(1);
        end
    end

    // Lock bookkeeping for the pair about to be published.
    assign pair_same   = (hi_tmp == high_len) && (cnt == low_len);
    assign match_nxt   = !pair_same            ? MW'(1)    :
                         (match_cnt == MATCH_MAX) ? match_cnt :
                                                   match_cnt + MW'(1);
    assign take_sample = rise && have_fall &&
                         ((state == ST_MEASURE) || (state == ST_LOCKED));
    assign timeout_hit = (cnt == CNT_MAX) && !any_edge;

    // Measurement FSM: arm on the first rise, capture the high phase on a
    // fall, publish the full period on the following rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            hi_tmp      <= '0;
            have_fall   <= 1'b0;
            match_cnt   <= '0;
            high_len    <= '0;
            low_len     <= '0;
            period      <= '0;
            valid       <= 1'b0;
            is_even     <= 1'b0;
            locked      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            // NOTE: valid defaults low every cycle so it can only ever be a
            // single-cycle pulse, whatever branch below is taken.
            valid <= 1'b0;
            if (!en) begin
                state       <= ST_IDLE;
                locked      <= 1'b0;
                timeout_err <= 1'b0;
                match_cnt   <= '0;
                have_fall   <= 1'b0;
            end else if (state == ST_IDLE) begin
                state <= ST_WAIT_RISE;
            end else if (timeout_hit) begin
                state       <= ST_WAIT_RISE;
                timeout_err <= 1'b1;
                locked      <= 1'b0;
                match_cnt   <= '0;
                have_fall   <= 1'b0;
            end else if (state == ST_WAIT_RISE) begin
                if (rise) begin
                    state     <= ST_MEASURE;
                    have_fall <= 1'b0;
                end
            end else if (fall) begin
                hi_tmp    <= cnt;
                have_fall <= 1'b1;
            end else if (rise) begin
                have_fall <= 1'b0;
                if (take_sample) begin
                    high_len  <= hi_tmp;
                    low_len   <= cnt;
                    period    <= {1'b0, hi_tmp} + {1'b0, cnt};
                    is_even   <= (hi_tmp == cnt);
                    valid     <= 1'b1;
                    match_cnt <= match_nxt;
                    if (match_nxt == MATCH_MAX) begin
                        locked <= 1'b1;
                        state  <= ST_LOCKED;
                    end else begin
                        locked <= 1'b0;
                        state  <= ST_MEASURE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Testbench for clk_div_monitor. The driver shapes clk_in as a sequence of
// (high,low) periods and pushes the result each finished period should
// produce; a monitor pops one expectation per valid pulse.
module tb_clk_div_monitor;

    localparam int MAX_DIV     = 16;
    localparam int LOCK_CNT    = 4;
    localparam int SYNC_STAGES = 2;
    localparam int W           = $clog2(MAX_DIV + 1);

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         clk_in;
    logic [W-1:0] high_len;
    logic [W-1:0] low_len;
    logic [W:0]   period;
    logic         valid;
    logic         is_even;
    logic         locked;
    logic         timeout_err;

    clk_div_monitor #(
        .MAX_DIV     (MAX_DIV),
        .LOCK_CNT    (LOCK_CNT),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .clk_in      (clk_in),
        .high_len    (high_len),
        .low_len     (low_len),
        .period      (period),
        .valid       (valid),
        .is_even     (is_even),
        .locked      (locked),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int hi;
        int lo;
        bit lck;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state
    bit en_m    = 1'b0;
    bit pending = 1'b0;  // a full period was driven after an arming rise
    bit arm     = 1'b0;
    int prev_h  = 0;
    int prev_l  = 0;
    int run     = 0;     // length of the current run of identical pairs
    int last_h  = -1;
    int last_l  = -1;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_expect(input int h, input int l);
        exp_t e;
        if (run > 0 && h == last_h && l == last_l) begin
            if (run < LOCK_CNT) run++;
        end else begin
            run = 1;
        end
        last_h = h;
        last_l = l;
        e.hi  = h;
        e.lo  = l;
        e.lck = (run >= LOCK_CNT);
        exp_q.push_back(e);
    endtask

    // Rising edge of clk_in: completes the previously driven period.
    task automatic drive_rise();
        clk_in = 1'b1;
        if (en_m && pending) push_expect(prev_h, prev_l);
        arm     = en_m;
        pending = 1'b0;
    endtask

    task automatic drive_period(input int h, input int l);
        drive_rise();
        tick(h);
        clk_in = 1'b0;
        tick(l);
        pending = arm && en_m;
        prev_h  = h;
        prev_l  = l;
    endtask

    task automatic set_en(input bit v);
        en      = v;
        en_m    = v;
        pending = 1'b0;
        run     = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_high_len"},    int'(high_len),    0);
        check({tag, "_low_len"},     int'(low_len),     0);
        check({tag, "_period"},      int'(period),      0);
        check({tag, "_valid"},       int'(valid),       0);
        check({tag, "_is_even"},     int'(is_even),     0);
        check({tag, "_locked"},      int'(locked),      0);
        check({tag, "_timeout_err"}, int'(timeout_err), 0);
    endtask

    // Monitor: every valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("high_len",    int'(high_len),    e.hi);
                check("low_len",     int'(low_len),     e.lo);
                check("period",      int'(period),      e.hi + e.lo);
                check("is_even",     int'(is_even),     int'(e.hi == e.lo));
                check("locked",      int'(locked),      int'(e.lck));
                check("timeout_err", int'(timeout_err), 0);
            end
        end
    end

    initial begin
        int h;
        int l;
        int n;

        rst_n  = 1'b0;
        en     = 1'b0;
        clk_in = 1'b0;
        tick(3);
        check_all_zero("reset");

        rst_n = 1'b1;
        set_en(1'b1);
        tick(4);

        // 3 high / 3 low: lock on the 4th valid
        repeat (6) drive_period(3, 3);

        // 2 high / 5 low
        repeat (6) drive_period(2, 5);

        // lock at 3/3, then switch to 5/5 and re-lock
        repeat (6) drive_period(3, 3);
        repeat (6) drive_period(5, 5);

        // hold clk_in high past MAX_DIV while locked
        drive_rise();
        tick(20);
        run     = 0;
        pending = 1'b0;
        check("timeout_set",        int'(timeout_err), 1);
        check("timeout_locked_low", int'(locked),      0);
        clk_in = 1'b0;
        set_en(1'b0);
        tick(1);
        check("timeout_cleared_by_en", int'(timeout_err), 0);
        set_en(1'b1);
        tick(4);

        // reset between a fall and a rise while measuring 3/3
        repeat (3) drive_period(3, 3);
        drive_rise();
        tick(3);
        clk_in = 1'b0;
        tick(1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        pending = 1'b0;
        run     = 0;
        tick(2);
        rst_n = 1'b1;
        tick(4);
        repeat (5) drive_period(3, 3);

        // disable while a 3/3 clock keeps running, then re-enable
        set_en(1'b0);
        repeat (3) drive_period(3, 3);
        check("disabled_locked", int'(locked), 0);
        check("disabled_valid",  int'(valid),  0);
        set_en(1'b1);
        repeat (5) drive_period(3, 3);

        // random ratios
        for (int seg = 0; seg < 8; seg++) begin
            h = int'($urandom_range(1, 12));
            l = int'($urandom_range(1, 12));
            n = int'($urandom_range(2, 6));
            repeat (n) drive_period(h, l);
        end

        // final rise publishes the last full period
        drive_period(3, 3);
        tick(6);
        check("outstanding_expectations", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
